// File: rtl/vde_pkg.sv
// vde_pkg
//   Definitions shared by the sprite path of the video display engine:
//   tile geometry, default tile-map size, and the widths of the
//   (sprite index, sprite row) beat passed from the tile fetcher to the
//   sprite emitter. The fetcher state enum also lives here so benches
//   and debug logic can name the states.
package vde_pkg;

  // Tiles are square, TILE_PX pixels on a side.
  localparam int TILE_PX        = 8;

  // Default map: 80x60 tiles, i.e. 640x480 pixels.
  localparam int MAP_WIDTH_DEF  = 80;
  localparam int MAP_HEIGHT_DEF = 60;

  // Beat fields consumed by the sprite emitter.
  localparam int SPRITE_IDX_W   = 9;
  localparam int SPRITE_ROW_W   = 4;

  // Tile fetcher sequencing: one beat is ADDR -> LATCH -> SEND.
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ADDR  = 2'd1,
    FETCH_LATCH = 2'd2,
    FETCH_SEND  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vde_tile_fetcher.sv
// vde_tile_fetcher
//   Producer side of the sprite-index stream. For every line_start_i it
//   walks one row of the tile map (MAP_WIDTH columns) and issues one
//   (sprite index, sprite row) beat per column on a valid/ready handshake.
//   frame_start_i rewinds to scanline 0 and abandons any activity.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rstn_i          asynchronous active-low reset
//   frame_start_i   one-cycle pulse, rewind to scanline 0 (highest priority)
//   line_start_i    one-cycle pulse, emit the next scanline
//   map_addr_o      tile map read address (registered)
//   map_data_i      tile map read data, one cycle after map_addr_o; [8:0] used
//   sprite_valid_o  beat valid
//   sprite_ready_i  consumer ready
//   sprite_data_o   sprite index of the beat
//   sprite_row_o    pixel row inside the sprite, {1'b0, scanline[2:0]}
//   busy_o          a line is being emitted or is queued
//   overrun_o       sticky: a line request arrived with the queue already full
module vde_tile_fetcher
  import vde_pkg::*;
#(
  parameter int MAP_WIDTH  = MAP_WIDTH_DEF,
  parameter int MAP_HEIGHT = MAP_HEIGHT_DEF,
  parameter int MAP_ADDR_W = 13
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    frame_start_i,
  input  logic                    line_start_i,
  output logic [MAP_ADDR_W-1:0]   map_addr_o,
  input  logic [15:0]             map_data_i,
  output logic                    sprite_valid_o,
  input  logic                    sprite_ready_i,
  output logic [SPRITE_IDX_W-1:0] sprite_data_o,
  output logic [SPRITE_ROW_W-1:0] sprite_row_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int LINES = MAP_HEIGHT * TILE_PX;
  localparam int TX_W  = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
  // y must be able to hold LINES itself, which marks an exhausted frame.
  localparam int Y_W   = $clog2(LINES + 1);

  localparam logic [TX_W-1:0]       TX_LAST  = TX_W'(MAP_WIDTH - 1);
  localparam logic [Y_W-1:0]        Y_END    = Y_W'(LINES);
  localparam logic [MAP_ADDR_W-1:0] ROW_STEP = MAP_ADDR_W'(MAP_WIDTH);

  fetch_state_e                state_q, state_d;
  logic [TX_W-1:0]             tx_q, tx_d;
  logic [Y_W-1:0]              y_q, y_d;
  logic [MAP_ADDR_W-1:0]       row_base_q, row_base_d;
  logic                        pending_q, pending_d;
  logic                        overrun_q, overrun_d;
  logic                        valid_q, valid_d;
  logic [SPRITE_IDX_W-1:0]     data_q, data_d;
  logic [SPRITE_ROW_W-1:0]     row_q, row_d;
  logic [MAP_ADDR_W-1:0]       addr_q, addr_d;

  logic [TX_W-1:0]             tx_inc;
  logic                        map_hi_unused;

  // Upper map word bits carry nothing for this block.
  assign map_hi_unused = ^map_data_i[15:SPRITE_IDX_W];

  assign tx_inc = tx_q + TX_W'(1);

  // State register. Every piece of state, including the output registers,
  // is captured here from the next-state values computed below.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= FETCH_IDLE;
      tx_q       <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      row_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state logic. The map address is loaded whenever the FSM enters
  // ADDR so that the synchronous map read returns data during LATCH.
  // row_base steps by one map row after the eighth scanline of a tile row,
  // which keeps the address generation free of a multiplier.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    valid_d    = valid_q;
    data_d     = data_q;
    row_d      = row_q;
    addr_d     = addr_q;

    case (state_q)
      FETCH_IDLE: begin
        if (pending_q || line_start_i) begin
          if (y_q < Y_END) begin
            state_d   = FETCH_ADDR;
            addr_d    = row_base_q + MAP_ADDR_W'(tx_q);
            // A fresh pulse arriving as a queued line is consumed
            // becomes the next queued line.
            pending_d = pending_q && line_start_i;
          end else begin
            // Frame exhausted: requests are discarded quietly.
            pending_d = 1'b0;
          end
        end
      end

      FETCH_ADDR: begin
        state_d = FETCH_LATCH;
      end

      FETCH_LATCH: begin
        data_d  = map_data_i[SPRITE_IDX_W-1:0];
        row_d   = {1'b0, y_q[2:0]};
        valid_d = 1'b1;
        state_d = FETCH_SEND;
      end

      FETCH_SEND: begin
        if (valid_q && sprite_ready_i) begin
          valid_d = 1'b0;
          if (tx_q < TX_LAST) begin
            tx_d    = tx_inc;
            addr_d  = row_base_q + MAP_ADDR_W'(tx_inc);
            state_d = FETCH_ADDR;
          end else begin
            tx_d    = '0;
            y_d     = y_q + Y_W'(1);
            if (y_q[2:0] == 3'd7) begin
              row_base_d = row_base_q + ROW_STEP;
            end
            state_d = FETCH_IDLE;
          end
        end
      end

      default: begin
        state_d = FETCH_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // One-deep line queue; a request that finds it full is flagged.
    if ((state_q != FETCH_IDLE) && line_start_i) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end
      pending_d = 1'b1;
    end

    // Frame restart overrides everything, including a beat mid-handshake
    // and a line request in the same cycle.
    if (frame_start_i) begin
      state_d    = FETCH_IDLE;
      valid_d    = 1'b0;
      y_d        = '0;
      tx_d       = '0;
      row_base_d = '0;
      pending_d  = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign map_addr_o     = addr_q;
  assign sprite_valid_o = valid_q;
  assign sprite_data_o  = data_q;
  assign sprite_row_o   = row_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = (state_q != FETCH_IDLE) || pending_q;

endmodule

// File: tb/tb_vde_tile_fetcher.sv
// tb_vde_tile_fetcher
//   Directed bench for vde_tile_fetcher. The map is 80 tiles wide and
//   6 tile rows tall (48 scanlines) so a full frame fits in a short run.
//   Map word k holds k in its low bits with junk in the top bits, so the
//   expected sprite index of a beat is its address modulo 512.
module tb_vde_tile_fetcher;

  localparam int W            = 80;
  localparam int H            = 6;
  localparam int AW           = 13;
  localparam int CYCLE_BUDGET = 20000;

  logic          clk_i;
  logic          rstn_i;
  logic          frame_start_i;
  logic          line_start_i;
  logic [AW-1:0] map_addr_o;
  logic [15:0]   map_data_i;
  logic          sprite_valid_o;
  logic          sprite_ready_i;
  logic [8:0]    sprite_data_o;
  logic [3:0]    sprite_row_o;
  logic          busy_o;
  logic          overrun_o;

  int checks  = 0;
  int errors  = 0;
  int curLine = 0;

  typedef struct {
    int lineNo;
    int readyPct;
    int expBase;
    int expRow;
  } lineVec_t;

  lineVec_t vecs[5];

  vde_tile_fetcher #(
    .MAP_WIDTH (W),
    .MAP_HEIGHT(H),
    .MAP_ADDR_W(AW)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .frame_start_i (frame_start_i),
    .line_start_i  (line_start_i),
    .map_addr_o    (map_addr_o),
    .map_data_i    (map_data_i),
    .sprite_valid_o(sprite_valid_o),
    .sprite_ready_i(sprite_ready_i),
    .sprite_data_o (sprite_data_o),
    .sprite_row_o  (sprite_row_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o)
  );

  // Clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Tile map memory, synchronous read with one cycle of latency.
  always @(posedge clk_i) begin
    map_data_i <= {3'b101, map_addr_o};
  end

  // Safety net in case a bounded loop is ever miscounted.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulseFrame();
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!sprite_valid_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    ok = sprite_valid_o;
  endtask

  // Optionally pulses line_start_i, then consumes nBeats beats with the
  // given ready probability, checking address, index and row of each beat
  // and that a stalled beat holds still. lat is the cycle (pulse = cycle 0)
  // on which valid was first seen.
  task automatic collectLine(input int readyPct, input int expBase, input int expRow,
                             input int nBeats, input bit doPulse, input bit checkEnd,
                             output int lat);
    int         beats;
    int         cycles;
    bit         seenValid;
    bit         stall;
    bit         rdy;
    logic [8:0] heldData;
    logic [3:0] heldRow;
    beats     = 0;
    cycles    = 0;
    seenValid = 1'b0;
    stall     = 1'b0;
    lat       = 0;
    heldData  = '0;
    heldRow   = '0;
    if (doPulse) begin
      line_start_i = 1'b1;
      @(posedge clk_i); #1;
      line_start_i = 1'b0;
    end
    while (beats < nBeats && cycles < CYCLE_BUDGET) begin
      rdy = ($urandom_range(99) < readyPct);
      sprite_ready_i = rdy;
      if (sprite_valid_o) begin
        if (!seenValid) begin
          seenValid = 1'b1;
          lat       = cycles + 1;
        end
        if (stall) begin
          checkOutput("holdData", sprite_data_o, heldData);
          checkOutput("holdRow", sprite_row_o, heldRow);
        end
        if (rdy) begin
          checkOutput("beatAddr", map_addr_o, expBase + beats);
          checkOutput("beatData", sprite_data_o, (expBase + beats) % 512);
          checkOutput("beatRow", sprite_row_o, expRow);
          beats++;
          stall = 1'b0;
        end else begin
          stall    = 1'b1;
          heldData = sprite_data_o;
          heldRow  = sprite_row_o;
        end
      end
      @(posedge clk_i); #1;
      cycles++;
    end
    checkOutput("beatCount", beats, nBeats);
    if (checkEnd) begin
      checkOutput("endValid", sprite_valid_o, 0);
      checkOutput("endBusy", busy_o, 0);
    end
  endtask

  // A full line whose expectations come from the line number.
  task automatic runModelLine(input int l);
    int lat;
    collectLine(100, (l / 8) * W, l % 8, W, 1'b1, 1'b1, lat);
    checkOutput($sformatf("line%0dLatency", l), lat, 3);
  endtask

  // Advances to the vector's line, then emits it against the table values.
  task automatic applyStimulus(input lineVec_t v);
    int lat;
    while (curLine < v.lineNo) begin
      runModelLine(curLine);
      curLine++;
    end
    collectLine(v.readyPct, v.expBase, v.expRow, W, 1'b1, 1'b1, lat);
    checkOutput($sformatf("vecLine%0dLatency", v.lineNo), lat, 3);
    curLine++;
  endtask

  initial begin
    int lat;
    int cnt;
    bit ok;

    rstn_i         = 1'b0;
    frame_start_i  = 1'b0;
    line_start_i   = 1'b0;
    sprite_ready_i = 1'b0;

    vecs[0] = '{lineNo: 0,  readyPct: 100, expBase: 0,   expRow: 0};
    vecs[1] = '{lineNo: 8,  readyPct: 100, expBase: 80,  expRow: 0};
    vecs[2] = '{lineNo: 9,  readyPct: 100, expBase: 80,  expRow: 1};
    vecs[3] = '{lineNo: 17, readyPct: 30,  expBase: 160, expRow: 1};
    vecs[4] = '{lineNo: 47, readyPct: 100, expBase: 400, expRow: 7};

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("resetValid", sprite_valid_o, 0);
    checkOutput("resetData", sprite_data_o, 0);
    checkOutput("resetRow", sprite_row_o, 0);
    checkOutput("resetAddr", map_addr_o, 0);
    checkOutput("resetBusy", busy_o, 0);
    checkOutput("resetOverrun", overrun_o, 0);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Whole frame, table driven.
    pulseFrame();
    curLine = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Frame exhausted: a further request is dropped without overrun.
    line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (sprite_valid_o) cnt++;
      if (busy_o) cnt++;
      @(posedge clk_i); #1;
    end
    checkOutput("exhaustActivity", cnt, 0);
    checkOutput("exhaustOverrun", overrun_o, 0);

    // Queueing: one request queued during line 3, a second one overruns.
    pulseFrame();
    for (int l = 0; l < 3; l++) runModelLine(l);
    fork
      begin
        collectLine(100, 0, 3, W, 1'b1, 1'b0, lat);
        checkOutput("line3Latency", lat, 3);
      end
      begin
        repeat (40) @(posedge clk_i);
        #1;
        line_start_i = 1'b1;
        @(posedge clk_i); #1;
        line_start_i = 1'b0;
        checkOutput("queueNoOverrun", overrun_o, 0);
        checkOutput("queueBusy", busy_o, 1);
        repeat (40) @(posedge clk_i);
        #1;
        line_start_i = 1'b1;
        @(posedge clk_i); #1;
        line_start_i = 1'b0;
        checkOutput("overrunSet", overrun_o, 1);
      end
    join
    checkOutput("pendingBusy", busy_o, 1);
    collectLine(100, 0, 4, W, 1'b0, 1'b1, lat);
    checkOutput("queuedLatency", lat, 4);
    cnt = 0;
    repeat (10) begin
      if (sprite_valid_o) cnt++;
      @(posedge clk_i); #1;
    end
    checkOutput("noThirdLine", cnt, 0);
    checkOutput("overrunSticky", overrun_o, 1);
    pulseFrame();
    checkOutput("overrunCleared", overrun_o, 0);
    checkOutput("frameBusy", busy_o, 0);

    // frame_start with beat 40 of line 5 offered and accepted the same cycle.
    for (int l = 0; l < 5; l++) runModelLine(l);
    collectLine(100, 0, 5, 40, 1'b1, 1'b0, lat);
    sprite_ready_i = 1'b0;
    waitValid(ok);
    checkOutput("abortValidUp", ok, 1);
    checkOutput("abortBeatData", sprite_data_o, 40);
    frame_start_i  = 1'b1;
    sprite_ready_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    checkOutput("abortValidDrop", sprite_valid_o, 0);
    checkOutput("abortBusy", busy_o, 0);
    cnt = 0;
    repeat (10) begin
      if (sprite_valid_o) cnt++;
      @(posedge clk_i); #1;
    end
    checkOutput("abortQuiet", cnt, 0);
    collectLine(100, 0, 0, W, 1'b1, 1'b1, lat);
    checkOutput("afterAbortLatency", lat, 3);

    // Asynchronous reset in the middle of a beat on scanline 1.
    collectLine(100, 0, 1, 10, 1'b1, 1'b0, lat);
    sprite_ready_i = 1'b0;
    waitValid(ok);
    checkOutput("asyncValidUp", ok, 1);
    #3 rstn_i = 1'b0;
    #1;
    checkOutput("asyncValid", sprite_valid_o, 0);
    checkOutput("asyncData", sprite_data_o, 0);
    checkOutput("asyncRow", sprite_row_o, 0);
    checkOutput("asyncAddr", map_addr_o, 0);
    checkOutput("asyncBusy", busy_o, 0);
    checkOutput("asyncOverrun", overrun_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i); #1;
    collectLine(100, 0, 0, W, 1'b1, 1'b1, lat);
    checkOutput("afterResetLatency", lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vde_tile_fetcher.md
Name: vde_tile_fetcher

Overview:
- Producer side of the sprite-index stream that feeds the sprite emitter.
- Walks the tile map row by row and issues one (sprite index, sprite row) beat per tile column over a valid/ready handshake.
- Generates one scanline's worth of beats (MAP_WIDTH tiles) per line_start_i pulse.
- Restarts at map line 0 on frame_start_i. Tiles are 8x8 pixels; the default map is 80x60 tiles, which gives 640x480 pixels.

Parameters:
- MAP_WIDTH, 80, tiles per map row.
- MAP_HEIGHT, 60, tile rows per map; scanlines per frame = MAP_HEIGHT*8.
- MAP_ADDR_W, 13, map memory address width; must satisfy 2^MAP_ADDR_W >= MAP_WIDTH*MAP_HEIGHT.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rstn_i  in  1  asynchronous, active-low reset.
- frame_start_i  in  1  one-cycle pulse; aborts any activity and rewinds to scanline 0.
- line_start_i  in  1  one-cycle pulse; requests emission of the next scanline.
- map_addr_o  out  MAP_ADDR_W  tile map read address.
- map_data_i  in  16  tile map read data, synchronous, 1-cycle latency; bits [8:0] = sprite index, [15:9] ignored.
- sprite_valid_o  out  1  beat valid.
- sprite_ready_i  in  1  consumer ready.
- sprite_data_o  out  9  sprite index.
- sprite_row_o  out  4  pixel row within the sprite, {1'b0, scanline[2:0]}.
- busy_o  out  1  high while a line is being emitted or is pending.
- overrun_o  out  1  sticky; set on a line_start_i that cannot be queued, cleared by frame_start_i or reset.

Behaviour:
- Reset values: state IDLE, sprite_valid_o=0, sprite_data_o=0, sprite_row_o=0, map_addr_o=0, busy_o=0, overrun_o=0. Internal scanline y=0, column tx=0, row_base=0, pending=0.
- Counters:
  - tx counts 0..MAP_WIDTH-1.
  - y counts 0..MAP_HEIGHT*8-1.
  - row_base = (y>>3)*MAP_WIDTH, maintained incrementally: +MAP_WIDTH when a line with y[2:0]==7 completes. No multiplier.
  - map_addr_o = row_base + tx, registered.
- States:
  - IDLE: if pending, or line_start_i this cycle, and y < MAP_HEIGHT*8: clear pending and go to ADDR. If y == MAP_HEIGHT*8 (frame exhausted), requests are dropped silently; this does not set overrun.
  - ADDR: map_addr_o holds row_base+tx; go to LATCH.
  - LATCH: capture map_data_i[8:0] into sprite_data_o and y[2:0] into sprite_row_o; set sprite_valid_o; go to SEND.
  - SEND:
    - sprite_valid_o held; sprite_data_o and sprite_row_o stable until the handshake.
    - On sprite_valid_o & sprite_ready_i: drop valid on the next cycle.
    - If tx < MAP_WIDTH-1: tx++, go to ADDR.
    - Else: tx=0, y++, update row_base, go to IDLE.
- Timing:
  - Minimum 3 cycles per beat.
  - First beat is valid 3 cycles after an accepted line_start_i when idle (pulse at cycle 0 -> valid at cycle 3).
  - sprite_valid_o never depends combinationally on sprite_ready_i.
- Line queueing:
  - One-deep pending flag.
  - line_start_i while state != IDLE sets pending.
  - line_start_i while pending is already set leaves pending=1 and sets overrun_o.
  - line_start_i in IDLE is consumed immediately.
- busy_o = (state != IDLE) | pending.
- frame_start_i (highest priority, synchronous):
  - Next cycle: state=IDLE, valid=0, y=0, tx=0, row_base=0, pending=0, overrun_o=0.
  - A line_start_i in the same cycle is ignored.
  - A beat mid-handshake is dropped without completing.
- Async reset asserted mid-line: all state returns to reset values immediately. The consumer sees valid fall without a handshake.

Decomposition:
- Shared package vde_pkg: TILE_PX=8, default MAP_WIDTH/MAP_HEIGHT, sprite index width (9), sprite row width (4). These are shared with the sprite emitter.
- Local fetcher FSM state enum in vde_pkg, so benches can probe it.
- No sub-module; single flat module, roughly 150-250 lines.

Test Plan:
- Reset, frame_start, one line_start with ready=1 and map word k = k -> 80 beats, sprite_data = 0..79, row=0; map_addr_o 0..79; first valid at cycle 3 after the pulse; busy_o falls after beat 79.
- Lines 8 and 9 (after 8 prior lines) -> addresses 80..159, row=0 then row=1 for both lines; line 479 -> addresses 4720..4799, row=7.
- Random sprite_ready_i backpressure (30% high) -> no beat lost or duplicated; data/row stable while valid & !ready.
- line_start during line 3, then two more pulses -> first queued (line 4 starts immediately after line 3 ends), second sets overrun_o=1; frame_start clears it.
- 481st line_start after line 479 -> no beats, overrun_o stays 0.
- frame_start at beat 40 of line 5 with valid high -> valid=0 next cycle; next line_start emits addr 0, row 0. Same test with rstn_i low mid-beat -> all outputs 0 asynchronously.
